trdb_packet_arbiter: RTL

Shares one `trdb_stream_align8` instance between `N_SRC` trace packet emitters for multi-core tracing. It selects one requester at a time and holds that selection until the aligner grants the whole packet. It also sequences stream flushes so a flush never interleaves with a packet in flight. It sits between the per-core packet emitters and the aligner's `packet_bits_i`/`valid_i`/`grant_o`/`flush_*` ports.

---
 rtl/trdb_packet_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/trdb_packet_arbiter.sv
// trdb_packet_arbiter
// Shares one trdb_stream_align8 between N_SRC packet emitters. One source is
// selected at a time and held until the aligner grants the whole packet.
// Stream flushes are sequenced so a flush never interleaves with a packet.
// Optional feature macro: TRDB_ARB_ROUND_ROBIN_EN (round-robin arbitration);
// without it the lowest-indexed requester wins.
module trdb_packet_arbiter #(
  parameter int N_SRC             = 2,
  parameter int CNT_W             = 16,
  parameter int PACKET_LEN        = 64,
  parameter int PACKET_HEADER_LEN = 7,
  localparam int SEL_W            = $clog2(N_SRC)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [N_SRC-1:0][PACKET_LEN-1:0]        src_packet_bits_i,
  input  logic [N_SRC-1:0][PACKET_HEADER_LEN-1:0] src_packet_len_i,
  input  logic [N_SRC-1:0]                        src_valid_i,
  output logic [N_SRC-1:0]                        src_grant_o,
  input  logic                                    flush_req_i,
  output logic                                    flush_done_o,
  output logic [PACKET_LEN-1:0]                   align_packet_bits_o,
  output logic [PACKET_HEADER_LEN-1:0]            align_packet_len_o,
  output logic                                    align_valid_o,
  input  logic                                    align_grant_i,
  output logic                                    align_flush_o,
  input  logic                                    align_flush_confirm_i,
  output logic [SEL_W-1:0]                        sel_id_o,
  output logic                                    busy_o,
  output logic [CNT_W-1:0]                        pkt_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, DONE} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [SEL_W-1:0]    win;

`ifdef TRDB_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  // Winner is the first valid source at or above the round-robin pointer, wrapping.
  always_comb begin
    int   idx;
    logic found;
    win   = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_SRC;
      if (!found && src_valid_i[idx]) begin
        win   = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest valid index as winner.
  always_comb begin
    win = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (src_valid_i[k]) win = SEL_W'(k);
    end
  end
`endif

  // Next-state, datapath mux and handshake outputs.
  always_comb begin
    state_d             = state_q;
    sel_d               = sel_q;
    pkt_cnt_d           = pkt_cnt_q;
    flush_pend_d        = flush_pend_q |
                          (flush_req_i && (state_q != FLUSH) && (state_q != DONE));
`ifdef TRDB_ARB_ROUND_ROBIN_EN
    rr_ptr_d            = rr_ptr_q;
`endif
    src_grant_o         = '0;
    flush_done_o        = 1'b0;
    align_packet_bits_o = '0;
    align_packet_len_o  = '0;
    align_valid_o       = 1'b0;
    align_flush_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else if (|src_valid_i) begin
          sel_d   = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        align_packet_bits_o = src_packet_bits_i[sel_q];
        align_packet_len_o  = src_packet_len_i[sel_q];
        align_valid_o       = src_valid_i[sel_q];
        if (align_grant_i) begin
          src_grant_o[sel_q] = 1'b1;
          if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
`ifdef TRDB_ARB_ROUND_ROBIN_EN
          rr_ptr_d = (int'(sel_q) == N_SRC - 1) ? '0 : sel_q + 1'b1;
`endif
          state_d = IDLE;
        end else if (!src_valid_i[sel_q]) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        align_flush_o = 1'b1;
        if (align_flush_confirm_i) state_d = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      flush_pend_q <= 1'b0;
      pkt_cnt_q    <= '0;
`ifdef TRDB_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      flush_pend_q <= flush_pend_d;
      pkt_cnt_q    <= pkt_cnt_d;
`ifdef TRDB_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign sel_id_o  = sel_q;
  assign busy_o    = (state_q != IDLE);
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
